vc_input_flow_ctrl: RTL
=======================

Name: vc_input_flow_ctrl

Overview:
- Parametrised input flow controller between the main ingress FIFO and N virtual-channel FIFOs.
- Reads the destination VC from the head word of the first-word-fall-through main FIFO and decides whether to pop it.
- Forwards each popped word through a registered output stage with a one-hot per-VC valid.
- Supports a global-pause mode and a per-destination-pause mode, drops error and mis-addressed words, holds off popping for a post-reset init window, and keeps saturating stall and error counters.

Parameters:
- DATA_WIDTH, 6: width of the data word.
- N_VC, 2: number of virtual channels. Must be ≥2.
- DEST_LSB, 4: bit position of the LSB of the destination field inside the data word.
- INIT_CYCLES, 2: cycles after reset release during which no pop is issued. 0 means no init window.
- CNT_WIDTH, 8: width of the stall and error counters.
- Derived localparam VC_SEL_W = clog2(N_VC): destination field width. dest = data_in_main[DEST_LSB +: VC_SEL_W].

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- mode, input, 1: 0 = global pause, 1 = per-destination pause. Sampled every cycle.
- fifo_pause_vc, input, N_VC: almost-full/pause flag from each VC FIFO.
- fifo_empty_main, input, 1: main FIFO empty.
- fifo_error_main, input, 1: main FIFO error flag, qualifying the current head word.
- data_in_main, input, DATA_WIDTH: head word of the main FIFO (FWFT).
- pop_main, output, 1: pop request to the main FIFO. Combinational from state and inputs.
- data_out, output, DATA_WIDTH: registered forwarded word.
- valid_out_vc, output, N_VC: registered one-hot valid. Bit i means data_out is for VC i.
- stall_count, output, CNT_WIDTH: saturating count of cycles spent in PAUSE.
- error_count, output, CNT_WIDTH: saturating count of dropped words.
- busy, output, 1: high when state is not INIT and (main FIFO non-empty or valid_out_vc ≠ 0).

Behaviour:
- Reset (async, while high):
  - state = INIT, init counter = 0.
  - data_out = 0, valid_out_vc = 0, stall_count = 0, error_count = 0.
  - pop_main = 0, busy = 0.
  - Assertion mid-operation clears the outputs immediately, without waiting for a clock edge.
- dest_ok = (dest < N_VC).
- blocked:
  - mode 0: |fifo_pause_vc.
  - mode 1: dest_ok & fifo_pause_vc[dest].
  - An out-of-range dest is never blocked in mode 1, so it is always drained.
- FSM states INIT, RUN, PAUSE:
  - INIT: pop_main = 0. Init counter increments each cycle. Go to RUN at the edge where counter == INIT_CYCLES-1. If INIT_CYCLES = 0, go to RUN on the first edge after reset release.
  - RUN: pop_main = !fifo_empty_main & !blocked. If !fifo_empty_main & blocked, go to PAUSE at the next edge.
  - PAUSE: pop_main = 0. stall_count increments by 1 per cycle, saturating at all-ones. Return to RUN when !blocked or fifo_empty_main. blocked is re-evaluated every cycle, so a mode change or head-word change takes effect immediately.
  - Resuming from PAUSE costs exactly one bubble cycle: no pop in the cycle the exit condition first holds.
- Output stage, one-cycle latency from pop:
  - Edge after pop_main = 1 with fifo_error_main = 0 and dest_ok: data_out ← data_in_main, valid_out_vc ← one-hot(dest).
  - Edge after pop_main = 1 with fifo_error_main = 1 or !dest_ok: word is consumed but not forwarded. valid_out_vc ← 0, error_count += 1 (saturating).
  - Any cycle without a pop: valid_out_vc ← 0, data_out holds its previous value.
- Throughput: one word per cycle in RUN while the FIFO is non-empty and not blocked.
- Empty while in RUN: stay in RUN, no pop, no stall counting.
- Simultaneous events within one cycle:
  - error plus pause in mode 0: pause wins, no pop, no error count.
  - error in mode 1 with the destination unpaused: popped and dropped.
- Never pop when fifo_empty_main = 1, in any state.

Test Plan:
1. INIT_CYCLES=4, FIFO non-empty, no pause, reset released → pop_main = 0 for 4 cycles, pop_main = 1 on cycle 5, first valid_out_vc on cycle 6.
2. N_VC=4, DEST_LSB=4, mode=1, head = 8'h2A (dest 2), fifo_pause_vc = 4'b0001 → pop_main = 1; next cycle data_out = 8'h2A, valid_out_vc = 4'b0100.
3. Same stimulus as scenario 2 with mode=0 → pop_main = 0, state PAUSE, stall_count increments by 1 per cycle. Clear the pause after 5 cycles → stall_count = 5, one bubble cycle, then pop_main = 1.
4. N_VC=3, head dest=3, then a valid word with fifo_error_main = 1 → both popped, valid_out_vc stays 0, error_count goes 0 → 2.
5. CNT_WIDTH=4, pause held for 20 cycles with the FIFO non-empty → stall_count saturates and stays at 4'hF.
6. Stream of 3 words at full rate, then reset asserted mid-clock while valid_out_vc ≠ 0 → all outputs and counters go to 0 without a clock edge, and the state returns to INIT.

Source files
------------

// File: rtl/vc_input_flow_ctrl_if.sv
// Bundle of the main-FIFO side, VC-side and status signals of the VC input
// flow controller. The master drives the FIFO flags and head word; the
// slave (the controller) returns the pop, the forwarded word and status.
interface vc_input_flow_ctrl_if #(
  parameter int DATA_WIDTH = 6,
  parameter int N_VC       = 2,
  parameter int CNT_WIDTH  = 8
);
  logic                  mode;
  logic [N_VC-1:0]       fifo_pause_vc;
  logic                  fifo_empty_main;
  logic                  fifo_error_main;
  logic [DATA_WIDTH-1:0] data_in_main;
  logic                  pop_main;
  logic [DATA_WIDTH-1:0] data_out;
  logic [N_VC-1:0]       valid_out_vc;
  logic [CNT_WIDTH-1:0]  stall_count;
  logic [CNT_WIDTH-1:0]  error_count;
  logic                  busy;

  modport master (
    output mode, fifo_pause_vc, fifo_empty_main, fifo_error_main, data_in_main,
    input  pop_main, data_out, valid_out_vc, stall_count, error_count, busy
  );

  modport slave (
    input  mode, fifo_pause_vc, fifo_empty_main, fifo_error_main, data_in_main,
    output pop_main, data_out, valid_out_vc, stall_count, error_count, busy
  );
endinterface

// File: rtl/vc_input_flow_ctrl.sv
// Input flow controller: pops the FWFT main FIFO toward N virtual channels,
// honouring a global or per-destination pause, dropping error and
// mis-addressed words, and counting stall cycles and dropped words.
module vc_input_flow_ctrl #(
  parameter int DATA_WIDTH  = 6,
  parameter int N_VC        = 2,
  parameter int DEST_LSB    = 4,
  parameter int INIT_CYCLES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input logic               clk,
  input logic               reset,
  vc_input_flow_ctrl_if.slave bus
);

  localparam int VC_SEL_W = (N_VC > 1) ? $clog2(N_VC) : 1;
  localparam int VC_SPAN  = 1 << VC_SEL_W;
  localparam int INIT_W   = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0]   INIT_LAST = INIT_W'((INIT_CYCLES > 1) ? INIT_CYCLES - 1 : 0);
  localparam logic [VC_SEL_W:0]   N_VC_EXT  = (VC_SEL_W + 1)'(N_VC);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_PAUSE} state_t;

  state_t                state_q, state_d;
  logic [INIT_W-1:0]     init_cnt_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [N_VC-1:0]       valid_q;
  logic [CNT_WIDTH-1:0]  stall_q;
  logic [CNT_WIDTH-1:0]  error_q;

  logic [VC_SEL_W-1:0]   dest;
  logic                  dest_ok;
  logic [VC_SPAN-1:0]    pause_pad;
  logic                  blocked;
  logic                  pop;
  logic [N_VC-1:0]       dest_onehot;

  assign dest        = bus.data_in_main[DEST_LSB +: VC_SEL_W];
  assign dest_ok     = ({1'b0, dest} < N_VC_EXT);
  assign dest_onehot = N_VC'(1) << dest;

  // Pause flags widened to the full dest range so an out-of-range dest reads 0.
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    pause_pad              = '0;
    pause_pad[N_VC-1:0]    = bus.fifo_pause_vc;
  end

  assign blocked = bus.mode ? (dest_ok & pause_pad[dest]) : (|bus.fifo_pause_vc);

  // FSM state register and init-window counter.
  // NOTE: asynchronous reset in the sensitivity list clears state immediately
  // on assertion; sequential state is only ever written with non-blocking <=.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + 1'b1;
    end
  end

  // Next-state and pop decision; PAUSE never pops, which yields the one-cycle
  // bubble on resume.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.fifo_empty_main) begin
          if (blocked) state_d = ST_PAUSE;
          else         pop     = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (!blocked || bus.fifo_empty_main) state_d = ST_RUN;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Registered output stage: forward good words, drop and count bad ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= '0;
      error_q <= '0;
    end else begin
      valid_q <= '0;
      if (pop) begin
        if (!bus.fifo_error_main && dest_ok) begin
          data_q  <= bus.data_in_main;
          valid_q <= dest_onehot;
        end else if (error_q != '1) begin
          error_q <= error_q + 1'b1;
        end
      end
    end
  end

  // Saturating count of cycles spent in PAUSE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state_q == ST_PAUSE && stall_q != '1) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.pop_main     = pop;
  assign bus.data_out     = data_q;
  assign bus.valid_out_vc = valid_q;
  assign bus.stall_count  = stall_q;
  assign bus.error_count  = error_q;
  assign bus.busy         = (state_q != ST_INIT) && (!bus.fifo_empty_main || (|valid_q));

endmodule
